// File: rtl/viola_pkg.sv
// viola_pkg: shared types and constants for the byte-serial memory controller.
// Holds the FSM state enum, lsb_size codes, RAM read latency and request record.
package viola_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  // Cycles from presenting mem_a to the byte appearing on mem_din.
  localparam int RD_LATENCY = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE:            return 3'd1;
      SIZE_HALF:            return 3'd2;
      SIZE_WORD, SIZE_RSVD: return 3'd4;
      default:              return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [2:0] n);
    case (n)
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_slot.sv
// mem_req_slot: one-deep pending-request holder. A set in the same cycle as a
// clear wins, so a requester can refill the slot on the edge it is consumed.
module mem_req_slot
  import viola_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  input  req_t req_in,
  output logic valid,
  output req_t req
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (set) begin
      valid <= 1'b1;
      req   <= req_in;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch and load/store traffic onto a byte-wide
// RAM with one-cycle read latency. LSB requests have fixed priority.
module mem_ctrl
  import viola_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_asking,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_ready,
  input  logic        if_flush,
  input  logic        lsb_req,
  input  logic        lsb_we,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_size,
  input  logic [31:0] lsb_wdata,
  output logic [31:0] lsb_data,
  output logic        lsb_ready,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr,
  input  logic [7:0]  mem_din
);

  localparam logic [2:0] RD_LAT3 = 3'(RD_LATENCY);

  state_t      state_reg, state_next;
  req_t        ic_in, lsb_in, ic_pend, lsb_pend, sel_req;
  logic        ic_valid, lsb_valid;
  logic        ic_set, ic_clr, lsb_set, lsb_clr;
  logic        can_start, start_ic, start_lsb, ic_active, lsb_active;
  logic        is_lsb_reg;
  logic [31:0] base_reg, wdata_reg, rd_buf_reg, rd_word;
  logic [31:0] if_data_reg, lsb_data_reg;
  logic [2:0]  n_reg, k_reg, rd_last, wr_last;
  logic [1:0]  rd_lane;

  assign ic_in  = '{addr: if_addr, size: SIZE_WORD, we: 1'b0, wdata: 32'd0};
  assign lsb_in = '{addr: lsb_addr, size: lsb_size, we: lsb_we, wdata: lsb_wdata};

  // DONE arbitrates exactly like IDLE so back-to-back requests lose no cycle.
  assign can_start  = (state_reg == IDLE) || (state_reg == DONE);
  assign start_lsb  = can_start && lsb_valid;
  assign start_ic   = can_start && !lsb_valid && ic_valid && !if_flush;
  assign ic_active  = (state_reg == RD) && !is_lsb_reg;
  assign lsb_active = ((state_reg == RD) || (state_reg == WR)) && is_lsb_reg;
  assign sel_req    = start_lsb ? lsb_pend : ic_pend;

  assign ic_set  = if_asking && !if_flush && (!ic_valid || start_ic) && !ic_active;
  assign ic_clr  = start_ic || if_flush;
  assign lsb_set = lsb_req && (!lsb_valid || start_lsb) && !lsb_active;
  assign lsb_clr = start_lsb;

  mem_req_slot u_ic_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .set    (ic_set),
    .clr    (ic_clr),
    .req_in (ic_in),
    .valid  (ic_valid),
    .req    (ic_pend)
  );

  mem_req_slot u_lsb_slot (
    .clk    (clk),
    .rst_n  (rst_n),
    .set    (lsb_set),
    .clr    (lsb_clr),
    .req_in (lsb_in),
    .valid  (lsb_valid),
    .req    (lsb_pend)
  );

  // A read spends N address cycles plus RD_LATENCY trailing capture cycles.
  assign rd_last = n_reg + RD_LAT3 - 3'd1;
  assign wr_last = n_reg - 3'd1;
  assign rd_lane = 2'(k_reg - RD_LAT3);

  always_comb begin
    rd_word = rd_buf_reg;
    rd_word[{rd_lane, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_lsb)     state_next = lsb_pend.we ? WR : RD;
        else if (start_ic) state_next = RD;
        else               state_next = IDLE;
      end
      RD: begin
        if (!is_lsb_reg && if_flush) state_next = IDLE;
        else if (k_reg == rd_last)   state_next = DONE;
      end
      WR: begin
        if (k_reg == wr_last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_a     = '0;
    mem_dout  = '0;
    mem_wr    = 1'b0;
    if_ready  = 1'b0;
    lsb_ready = 1'b0;
    case (state_reg)
      RD: begin
        if (k_reg < n_reg) mem_a = base_reg + {29'd0, k_reg};
      end
      WR: begin
        mem_wr   = 1'b1;
        mem_a    = base_reg + {29'd0, k_reg};
        mem_dout = wdata_reg[{k_reg[1:0], 3'b000} +: 8];
      end
      DONE: begin
        lsb_ready = is_lsb_reg;
        if_ready  = !is_lsb_reg && !if_flush;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_lsb_reg   <= 1'b0;
      base_reg     <= '0;
      wdata_reg    <= '0;
      n_reg        <= '0;
      k_reg        <= '0;
      rd_buf_reg   <= '0;
      if_data_reg  <= '0;
      lsb_data_reg <= '0;
    end else begin
      if (start_lsb || start_ic) begin
        is_lsb_reg <= start_lsb;
        base_reg   <= sel_req.addr;
        wdata_reg  <= sel_req.wdata;
        n_reg      <= size_bytes(sel_req.size);
        k_reg      <= '0;
      end else if ((state_reg == RD) || (state_reg == WR)) begin
        k_reg <= k_reg + 3'd1;
      end
      if ((state_reg == RD) && (k_reg >= RD_LAT3)) rd_buf_reg <= rd_word;
      // Result registers change only when the word is complete, so they hold until the next ready.
      if ((state_reg == RD) && (state_next == DONE)) begin
        if (is_lsb_reg) lsb_data_reg <= rd_word & lane_mask(n_reg);
        else            if_data_reg  <= rd_word;
      end
    end
  end

  assign if_data  = if_data_reg;
  assign lsb_data = lsb_data_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of fetch/load/store timing and memory contents.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_asking = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_data;
  logic        if_ready;
  logic        if_flush = 1'b0;
  logic        lsb_req = 1'b0;
  logic        lsb_we = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [1:0]  lsb_size = '0;
  logic [31:0] lsb_wdata = '0;
  logic [31:0] lsb_data;
  logic        lsb_ready;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din = '0;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] ram    [bit [31:0]];
  logic [7:0] shadow [bit [31:0]];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_asking (if_asking),
    .if_addr   (if_addr),
    .if_data   (if_data),
    .if_ready  (if_ready),
    .if_flush  (if_flush),
    .lsb_req   (lsb_req),
    .lsb_we    (lsb_we),
    .lsb_addr  (lsb_addr),
    .lsb_size  (lsb_size),
    .lsb_wdata (lsb_wdata),
    .lsb_data  (lsb_data),
    .lsb_ready (lsb_ready),
    .mem_a     (mem_a),
    .mem_dout  (mem_dout),
    .mem_wr    (mem_wr),
    .mem_din   (mem_din)
  );

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] sh_rd(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return init_byte(a);
  endfunction

  function automatic logic [31:0] sh_word(input logic [31:0] base, input int n);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = sh_rd(base + 32'(k));
    return w;
  endfunction

  // RAM: one-cycle read latency, byte write on mem_wr.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  // Transaction-level model: pending flags per port plus the active access and its step.
  bit          ic_v, ls_v, ls_we, m_act, m_lsb, m_we;
  logic [31:0] ic_a, ls_a, ls_wd, m_base, m_wdata, exp_if, exp_lsb;
  logic [1:0]  ls_sz;
  int          m_n, m_s;

  task automatic model_clear();
    ic_v = 0; ls_v = 0; m_act = 0; exp_if = '0; exp_lsb = '0;
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  task automatic model_edge();
    bit free;
    int last;
    if (!rst_n) begin
      model_clear();
      return;
    end
    free = !m_act;
    if (m_act) begin
      last = m_we ? m_n : m_n + 1;
      if (m_we && m_s < m_n) shadow[m_base + 32'(m_s)] = m_wdata[8*m_s +: 8];
      if (!m_lsb && if_flush && m_s < last) begin
        m_act = 0;
      end else if (m_s == last) begin
        m_act = 0;
        free = 1;
      end else begin
        if (!m_we && m_s == m_n) begin
          if (m_lsb) exp_lsb = sh_word(m_base, m_n);
          else       exp_if  = sh_word(m_base, 4);
        end
        m_s++;
      end
    end
    if (free) begin
      if (ls_v) begin
        m_act = 1; m_lsb = 1; m_we = ls_we; m_base = ls_a; m_wdata = ls_wd;
        m_n = nbytes(ls_sz); m_s = 0; ls_v = 0;
      end else if (ic_v && !if_flush) begin
        m_act = 1; m_lsb = 0; m_we = 0; m_base = ic_a; m_wdata = '0;
        m_n = 4; m_s = 0; ic_v = 0;
      end
    end
    if (if_flush) ic_v = 0;
    else if (if_asking) begin ic_v = 1; ic_a = if_addr; end
    if (lsb_req) begin
      ls_v = 1; ls_we = lsb_we; ls_a = lsb_addr; ls_sz = lsb_size; ls_wd = lsb_wdata;
    end
  endtask

  task automatic compare();
    bit exp_wr, done, exp_ifr;
    if (!rst_n) begin
      check("rst_mem_wr", 32'(mem_wr), 0);
      check("rst_mem_a", mem_a, 0);
      check("rst_mem_dout", 32'(mem_dout), 0);
      check("rst_if_ready", 32'(if_ready), 0);
      check("rst_lsb_ready", 32'(lsb_ready), 0);
      check("rst_if_data", if_data, 0);
      check("rst_lsb_data", lsb_data, 0);
      model_clear();
      return;
    end
    exp_wr = m_act && m_we && (m_s < m_n);
    done = m_act && (m_s == (m_we ? m_n : m_n + 1));
    exp_ifr = done && !m_lsb && !if_flush;
    check("mem_wr", 32'(mem_wr), 32'(exp_wr));
    if (m_act && m_s < m_n) check("mem_a", mem_a, m_base + 32'(m_s));
    if (exp_wr) check("mem_dout", 32'(mem_dout), 32'(m_wdata[8*m_s +: 8]));
    check("if_ready", 32'(if_ready), 32'(exp_ifr));
    check("lsb_ready", 32'(lsb_ready), 32'(done && m_lsb));
    if (exp_ifr) check("if_data", if_data, exp_if);
    check("lsb_data", lsb_data, exp_lsb);
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    shadow[a] = b;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    return 32'($urandom_range(0, 63));
  endfunction

  logic [31:0] wexp;
  bit ic_out, lsb_out;

  initial begin
    // Reset state
    mid();
    check("reset_if_ready", 32'(if_ready), 0);
    check("reset_mem_wr", 32'(mem_wr), 0);
    check("reset_mem_a", mem_a, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Fetch of 13 00 00 00 at 0x100
    poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    step(); if_asking = 1; if_addr = 32'h100;
    step(); if_asking = 0; if_addr = 32'hDEAD_0000;
    for (int t = 1; t <= 6; t++) begin
      step(); mid();
      if (t <= 4) check("fetch_addr", mem_a, 32'h100 + 32'(t) - 32'd1);
      if (t == 5) check("fetch_early", 32'(if_ready), 0);
      if (t == 6) begin
        check("fetch_ready", 32'(if_ready), 1);
        check("fetch_data", if_data, 32'h0000_0013);
      end
    end

    // Store word 0xDEADBEEF to 0x20
    wexp = 32'hDEAD_BEEF;
    step(); lsb_req = 1; lsb_we = 1; lsb_addr = 32'h20; lsb_size = 2'b10; lsb_wdata = wexp;
    step(); lsb_req = 0; lsb_we = 0; lsb_wdata = '0;
    for (int t = 1; t <= 5; t++) begin
      step(); mid();
      if (t <= 4) begin
        check("store_wr", 32'(mem_wr), 1);
        check("store_addr", mem_a, 32'h20 + 32'(t) - 32'd1);
        check("store_byte", 32'(mem_dout), 32'(wexp[8*(t-1) +: 8]));
      end else begin
        check("store_ready", 32'(lsb_ready), 1);
        check("store_wr_off", 32'(mem_wr), 0);
      end
    end

    // Load half across the address wrap
    poke(32'hFFFF_FFFF, 8'h34); poke(32'h0, 8'h12);
    step(); lsb_req = 1; lsb_we = 0; lsb_addr = 32'hFFFF_FFFF; lsb_size = 2'b01;
    step(); lsb_req = 0;
    for (int t = 1; t <= 4; t++) begin
      step(); mid();
      if (t == 1) check("wrap_addr0", mem_a, 32'hFFFF_FFFF);
      if (t == 2) check("wrap_addr1", mem_a, 32'h0);
      if (t == 3) check("wrap_early", 32'(lsb_ready), 0);
      if (t == 4) begin
        check("wrap_ready", 32'(lsb_ready), 1);
        check("wrap_data", lsb_data, 32'h0000_1234);
      end
    end

    // Simultaneous fetch and load byte: LSB first
    step(); if_asking = 1; if_addr = 32'h100;
    lsb_req = 1; lsb_we = 0; lsb_addr = 32'h20; lsb_size = 2'b00;
    step(); if_asking = 0; lsb_req = 0;
    for (int t = 1; t <= 9; t++) begin
      step(); mid();
      if (t == 3) begin
        check("prio_lsb_ready", 32'(lsb_ready), 1);
        check("prio_lsb_data", lsb_data, 32'h0000_00EF);
      end
      if (t == 8) check("prio_ic_early", 32'(if_ready), 0);
      if (t == 9) begin
        check("prio_ic_ready", 32'(if_ready), 1);
        check("prio_ic_data", if_data, 32'h0000_0013);
      end
    end

    // Flush two cycles into a fetch, then a fresh fetch
    poke(32'h104, 8'h93); poke(32'h105, 8'h00); poke(32'h106, 8'h10); poke(32'h107, 8'h00);
    step(); if_asking = 1; if_addr = 32'h100;
    step(); if_asking = 0;
    for (int t = 1; t <= 8; t++) begin
      step(); if_flush = (t == 2); mid();
      check("flush_no_ready", 32'(if_ready), 0);
    end
    step(); if_flush = 0; if_asking = 1; if_addr = 32'h104;
    step(); if_asking = 0;
    for (int t = 1; t <= 6; t++) begin
      step(); mid();
      if (t == 6) begin
        check("refetch_ready", 32'(if_ready), 1);
        check("refetch_data", if_data, 32'h0010_0093);
      end
    end

    // Reset during the second write byte
    step(); lsb_req = 1; lsb_we = 1; lsb_addr = 32'h40; lsb_size = 2'b10; lsb_wdata = 32'h1122_3344;
    step(); lsb_req = 0; lsb_we = 0;
    step(); mid();
    check("rstw_byte0", 32'(mem_wr), 1);
    step(); #2;
    check("rstw_byte1_addr", mem_a, 32'h41);
    rst_n = 1'b0;
    #1;
    check("rstw_wr_off", 32'(mem_wr), 0);
    check("rstw_addr_zero", mem_a, 0);
    check("rstw_if_data_zero", if_data, 0);
    step(); step();
    rst_n = 1'b1;
    for (int t = 0; t < 8; t++) begin
      step(); mid();
      check("rstw_no_ready", 32'(lsb_ready), 0);
      check("rstw_no_wr", 32'(mem_wr), 0);
    end
    check("rstw_ram40", 32'(ram_rd(32'h40)), 32'h44);
    check("rstw_ram41", 32'(ram_rd(32'h41)), 32'(init_byte(32'h41)));
    check("rstw_ram42", 32'(ram_rd(32'h42)), 32'(init_byte(32'h42)));

    // Randomized traffic with requester handshake discipline
    ic_out = 0;
    lsb_out = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if_flush = ($urandom_range(0, 15) == 0);
      #1;
      if (if_flush || if_ready) ic_out = 0;
      if (lsb_ready) lsb_out = 0;
      if_asking = 0;
      lsb_req = 0;
      if_addr = rand_addr();
      lsb_addr = rand_addr();
      lsb_wdata = $urandom;
      lsb_we = 1'($urandom_range(0, 1));
      lsb_size = 2'($urandom_range(0, 3));
      if (!ic_out && $urandom_range(0, 2) == 0) begin
        if_asking = 1;
        if (!if_flush) ic_out = 1;
      end
      if (!lsb_out && $urandom_range(0, 2) == 0) begin
        lsb_req = 1;
        lsb_out = 1;
      end
    end
    step();
    if_asking = 0; lsb_req = 0; if_flush = 0;
    for (int t = 0; t < 20; t++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
